bram_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port 256x64 behavioral BRAM (addr, data, wen, rdata) between two requesters.
- Accepts at most one read or write per cycle over a valid/ready handshake.
- Drives the BRAM port.
- Tracks in-flight reads so each read result returns to the requester that issued it.
- Sits between client logic and the BRAM (behavioral or implementation instance); same port shape in both cases.

---
 rtl/bram_rr_arbiter.sv | 102 ++++++++++
 tb/tb_bram_rr_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between two requesters,
// steering each read result back to the requester that issued it.
module bram_rr_arbiter #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_wen,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_wen,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wen,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic                    prio_q;  // 0 favours requester 0, 1 favours requester 1
    logic                    grant0;
    logic                    grant1;
    logic                    read_hs;
    logic [READ_LATENCY-1:0] pipe_valid_q;
    logic [READ_LATENCY-1:0] pipe_id_q;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (req0_valid && (!req1_valid || !prio_q)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    always_comb begin
        req0_ready = grant0;
        req1_ready = grant1;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wen    = 1'b0;
        read_hs    = 1'b0;
        if (grant0) begin
            mem_addr  = req0_addr;
            mem_wdata = req0_wdata;
            mem_wen   = req0_wen;
            read_hs   = !req0_wen;
        end else if (grant1) begin
            mem_addr  = req1_addr;
            mem_wdata = req1_wdata;
            mem_wen   = req1_wen;
            read_hs   = !req1_wen;
        end
    end

    // The tag pipeline tracks the BRAM read latency so the last stage lines up with mem_rdata.
    always_ff @(posedge clock) begin
        if (reset) begin
            prio_q       <= 1'b0;
            pipe_valid_q <= '0;
            pipe_id_q    <= '0;
            rsp0_valid   <= 1'b0;
            rsp1_valid   <= 1'b0;
            rsp0_rdata   <= '0;
            rsp1_rdata   <= '0;
        end else begin
            if (grant0) begin
                prio_q <= 1'b1;
            end else if (grant1) begin
                prio_q <= 1'b0;
            end
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_id_q[i]    <= pipe_id_q[i-1];
            end
            pipe_valid_q[0] <= read_hs;
            pipe_id_q[0]    <= grant1;
            rsp0_valid <= pipe_valid_q[READ_LATENCY-1] && !pipe_id_q[READ_LATENCY-1];
            rsp1_valid <= pipe_valid_q[READ_LATENCY-1] && pipe_id_q[READ_LATENCY-1];
            if (pipe_valid_q[READ_LATENCY-1] && !pipe_id_q[READ_LATENCY-1]) begin
                rsp0_rdata <= mem_rdata;
            end
            if (pipe_valid_q[READ_LATENCY-1] && pipe_id_q[READ_LATENCY-1]) begin
                rsp1_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Directed bench for bram_rr_arbiter: one latency-1 and one latency-2 instance,
// each attached to its own behavioural BRAM model.
`timescale 1ns/1ps
module tb_bram_rr_arbiter;

    logic        clock;
    logic        reset;
    int          n_tests;
    int          n_fail;

    logic        req0_valid, req0_ready, req0_wen, rsp0_valid;
    logic [7:0]  req0_addr;
    logic [63:0] req0_wdata, rsp0_rdata;
    logic        req1_valid, req1_ready, req1_wen, rsp1_valid;
    logic [7:0]  req1_addr;
    logic [63:0] req1_wdata, rsp1_rdata;
    logic [7:0]  mem_addr;
    logic [63:0] mem_wdata, mem_rdata;
    logic        mem_wen;

    logic        b_req0_valid, b_req0_ready, b_req0_wen, b_rsp0_valid;
    logic [7:0]  b_req0_addr;
    logic [63:0] b_req0_wdata, b_rsp0_rdata;
    logic        b_req1_valid, b_req1_ready, b_req1_wen, b_rsp1_valid;
    logic [7:0]  b_req1_addr;
    logic [63:0] b_req1_wdata, b_rsp1_rdata;
    logic [7:0]  b_mem_addr;
    logic [63:0] b_mem_wdata, b_mem_rdata;
    logic        b_mem_wen;

    logic [63:0] mem1 [256];
    logic [63:0] mem2 [256];
    logic [63:0] rd1_q, rd2a_q, rd2b_q;

    bram_rr_arbiter #(.ADDR_W(8), .DATA_W(64), .READ_LATENCY(1)) u_dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wen(req0_wen),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wen(req1_wen),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
        .mem_rdata(mem_rdata)
    );

    bram_rr_arbiter #(.ADDR_W(8), .DATA_W(64), .READ_LATENCY(2)) u_dut2 (
        .clock(clock), .reset(reset),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_wen(b_req0_wen),
        .req0_addr(b_req0_addr), .req0_wdata(b_req0_wdata),
        .rsp0_valid(b_rsp0_valid), .rsp0_rdata(b_rsp0_rdata),
        .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_wen(b_req1_wen),
        .req1_addr(b_req1_addr), .req1_wdata(b_req1_wdata),
        .rsp1_valid(b_rsp1_valid), .rsp1_rdata(b_rsp1_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wen(b_mem_wen),
        .mem_rdata(b_mem_rdata)
    );

    // Behavioural BRAMs: one-cycle and two-cycle read latency
    always @(posedge clock) begin
        if (mem_wen) mem1[mem_addr] <= mem_wdata;
        rd1_q <= mem1[mem_addr];
        if (b_mem_wen) mem2[b_mem_addr] <= b_mem_wdata;
        rd2a_q <= mem2[b_mem_addr];
        rd2b_q <= rd2a_q;
    end
    assign mem_rdata   = rd1_q;
    assign b_mem_rdata = rd2b_q;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic cycle_start();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0_valid = 1'b1; req0_wen = 1'b1; req0_addr = 8'h01; req0_wdata = 64'h1;
        req1_valid = 1'b1; req1_wen = 1'b1; req1_addr = 8'h02; req1_wdata = 64'h2;
        #1;
        n_tests++;
        if ({req0_ready, req1_ready, mem_wen} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_gating_pre_edge: got %b required 000",
                     {req0_ready, req1_ready, mem_wen});
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            @(negedge clock);
            n_tests++;
            if ({req0_ready, req1_ready, mem_wen, rsp0_valid, rsp1_valid} !== 5'b00000) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: ready0/ready1/wen/rsp0/rsp1 got %b required 00000",
                         i, {req0_ready, req1_ready, mem_wen, rsp0_valid, rsp1_valid});
            end
        end
    endtask

    task automatic test_solo();
        for (int i = 0; i < 8; i++) begin
            cycle_start();
            reset = 1'b0;
            req1_valid = 1'b0;
            req0_valid = 1'b1; req0_wen = 1'b1;
            req0_addr = 8'(i); req0_wdata = 64'(i + 16);
            @(negedge clock);
            n_tests++;
            if ({req0_ready, req1_ready, mem_wen} !== 3'b101 || mem_addr !== 8'(i)
                || mem_wdata !== 64'(i + 16)) begin
                n_fail++;
                $display("FAIL solo_write %0d: rdy/wen %b addr %0h data %0h required 101 %0h %0h",
                         i, {req0_ready, req1_ready, mem_wen}, mem_addr, mem_wdata, i, i + 16);
            end
        end
        for (int k = 0; k < 11; k++) begin
            cycle_start();
            req0_valid = (k < 8); req0_wen = 1'b0; req0_addr = 8'(k);
            @(negedge clock);
            if (k < 8) begin
                n_tests++;
                if (req0_ready !== 1'b1 || mem_wen !== 1'b0) begin
                    n_fail++;
                    $display("FAIL solo_read_grant %0d: ready %b wen %b required 1 0",
                             k, req0_ready, mem_wen);
                end
            end
            n_tests++;
            if (rsp0_valid !== (k >= 2 && k <= 9) || rsp1_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL solo_rsp_valid k=%0d: rsp0 %b rsp1 %b required %b 0",
                         k, rsp0_valid, rsp1_valid, (k >= 2 && k <= 9));
            end
            if (k >= 2 && k <= 9) begin
                n_tests++;
                if (rsp0_rdata !== 64'(k - 2 + 16)) begin
                    n_fail++;
                    $display("FAIL solo_rsp_data k=%0d: got %0h required %0h",
                             k, rsp0_rdata, k - 2 + 16);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        cycle_start();
        reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle_start();
            reset = 1'b0;
            req0_valid = (k < 8); req0_wen = 1'b0; req0_addr = 8'h03;
            req1_valid = (k < 8); req1_wen = 1'b0; req1_addr = 8'h05;
            @(negedge clock);
            if (k < 8) begin
                n_tests++;
                if ({req0_ready, req1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)
                    || mem_addr !== ((k % 2 == 0) ? 8'h03 : 8'h05)) begin
                    n_fail++;
                    $display("FAIL rr_grant k=%0d: ready %b addr %0h required %s",
                             k, {req0_ready, req1_ready}, mem_addr,
                             (k % 2 == 0) ? "10 03" : "01 05");
                end
            end
            n_tests++;
            if (k < 2) begin
                if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL rr_rsp_early k=%0d: got %b required 00",
                             k, {rsp0_valid, rsp1_valid});
                end
            end else if (k % 2 == 0) begin
                if ({rsp0_valid, rsp1_valid} !== 2'b10 || rsp0_rdata !== 64'h13) begin
                    n_fail++;
                    $display("FAIL rr_rsp0 k=%0d: valid %b data %0h required 10 13",
                             k, {rsp0_valid, rsp1_valid}, rsp0_rdata);
                end
            end else begin
                if ({rsp0_valid, rsp1_valid} !== 2'b01 || rsp1_rdata !== 64'h15) begin
                    n_fail++;
                    $display("FAIL rr_rsp1 k=%0d: valid %b data %0h required 01 15",
                             k, {rsp0_valid, rsp1_valid}, rsp1_rdata);
                end
            end
        end
    endtask

    task automatic test_same_cycle();
        cycle_start();
        reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle_start();
            reset = 1'b0;
            req0_valid = (k == 0); req0_wen = 1'b1; req0_addr = 8'h09; req0_wdata = 64'hAA;
            req1_valid = (k <= 1); req1_wen = 1'b0; req1_addr = 8'h09;
            @(negedge clock);
            n_tests++;
            case (k)
                0: if ({req0_ready, req1_ready, mem_wen} !== 3'b101 || mem_addr !== 8'h09) begin
                    n_fail++;
                    $display("FAIL same_cycle_first: rdy/wen %b addr %0h required 101 09",
                             {req0_ready, req1_ready, mem_wen}, mem_addr);
                end
                1: if ({req0_ready, req1_ready, mem_wen} !== 3'b010 || mem_addr !== 8'h09) begin
                    n_fail++;
                    $display("FAIL same_cycle_second: rdy/wen %b addr %0h required 010 09",
                             {req0_ready, req1_ready, mem_wen}, mem_addr);
                end
                3: if ({rsp0_valid, rsp1_valid} !== 2'b01 || rsp1_rdata !== 64'hAA) begin
                    n_fail++;
                    $display("FAIL same_cycle_rsp: valid %b data %0h required 01 aa",
                             {rsp0_valid, rsp1_valid}, rsp1_rdata);
                end
                default: if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL same_cycle_idle k=%0d: valid %b required 00",
                             k, {rsp0_valid, rsp1_valid});
                end
            endcase
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 7; k++) begin
            cycle_start();
            reset = (k == 1);
            req1_valid = (k == 0 || k == 2); req1_wen = 1'b0; req1_addr = 8'h05;
            req0_valid = (k == 2); req0_wen = 1'b0; req0_addr = 8'h03;
            @(negedge clock);
            if (k == 0) begin
                n_tests++;
                if (req1_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL mid_reset_issue: ready1 %b required 1", req1_ready);
                end
            end
            if (k == 2) begin
                n_tests++;
                if ({req0_ready, req1_ready} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL mid_reset_prio: ready %b required 10",
                             {req0_ready, req1_ready});
                end
            end
            n_tests++;
            if (rsp1_valid !== 1'b0 || rsp0_valid !== (k == 4)) begin
                n_fail++;
                $display("FAIL mid_reset_rsp k=%0d: rsp0 %b rsp1 %b required %b 0",
                         k, rsp0_valid, rsp1_valid, (k == 4));
            end
            if (k == 4) begin
                n_tests++;
                if (rsp0_rdata !== 64'h13) begin
                    n_fail++;
                    $display("FAIL mid_reset_data: got %0h required 13", rsp0_rdata);
                end
            end
        end
    endtask

    task automatic test_addr_ff();
        for (int k = 0; k < 5; k++) begin
            cycle_start();
            req0_valid = 1'b0;
            req1_valid = (k <= 1); req1_wen = (k == 0); req1_addr = 8'hFF;
            req1_wdata = 64'hDEAD_BEEF_CAFE_F00D;
            @(negedge clock);
            if (k == 0) begin
                n_tests++;
                if ({req1_ready, mem_wen} !== 2'b11 || mem_addr !== 8'hFF
                    || mem_wdata !== 64'hDEAD_BEEF_CAFE_F00D) begin
                    n_fail++;
                    $display("FAIL addr_ff_write: rdy/wen %b addr %0h data %0h",
                             {req1_ready, mem_wen}, mem_addr, mem_wdata);
                end
            end
            n_tests++;
            if ({rsp0_valid, rsp1_valid} !== ((k == 3) ? 2'b01 : 2'b00)
                || (k == 3 && rsp1_rdata !== 64'hDEAD_BEEF_CAFE_F00D)) begin
                n_fail++;
                $display("FAIL addr_ff_rsp k=%0d: valid %b data %0h required %b deadbeefcafef00d",
                         k, {rsp0_valid, rsp1_valid}, rsp1_rdata, (k == 3) ? 2'b01 : 2'b00);
            end
        end
    endtask

    task automatic test_latency2();
        for (int i = 0; i < 16; i++) begin
            cycle_start();
            b_req1_valid = 1'b0;
            b_req0_valid = 1'b1; b_req0_wen = 1'b1;
            b_req0_addr = 8'(i); b_req0_wdata = 64'(32'h5A00 + i);
        end
        for (int k = 0; k < 20; k++) begin
            int j;
            cycle_start();
            b_req0_valid = (k < 16) && (k % 2 == 0); b_req0_wen = 1'b0; b_req0_addr = 8'(k);
            b_req1_valid = (k < 16) && (k % 2 == 1); b_req1_wen = 1'b0; b_req1_addr = 8'(k);
            @(negedge clock);
            if (k < 16) begin
                n_tests++;
                if ({b_req0_ready, b_req1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL lat2_grant k=%0d: ready %b", k, {b_req0_ready, b_req1_ready});
                end
            end
            j = k - 3;
            n_tests++;
            if (k < 3 || k > 18) begin
                if ({b_rsp0_valid, b_rsp1_valid} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL lat2_idle k=%0d: valid %b required 00",
                             k, {b_rsp0_valid, b_rsp1_valid});
                end
            end else if (j % 2 == 0) begin
                if ({b_rsp0_valid, b_rsp1_valid} !== 2'b10 || b_rsp0_rdata !== 64'(32'h5A00 + j)) begin
                    n_fail++;
                    $display("FAIL lat2_rsp0 k=%0d: valid %b data %0h required 10 %0h",
                             k, {b_rsp0_valid, b_rsp1_valid}, b_rsp0_rdata, 32'h5A00 + j);
                end
            end else begin
                if ({b_rsp0_valid, b_rsp1_valid} !== 2'b01 || b_rsp1_rdata !== 64'(32'h5A00 + j)) begin
                    n_fail++;
                    $display("FAIL lat2_rsp1 k=%0d: valid %b data %0h required 01 %0h",
                             k, {b_rsp0_valid, b_rsp1_valid}, b_rsp1_rdata, 32'h5A00 + j);
                end
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        b_req0_valid = 1'b0; b_req0_wen = 1'b0; b_req0_addr = '0; b_req0_wdata = '0;
        b_req1_valid = 1'b0; b_req1_wen = 1'b0; b_req1_addr = '0; b_req1_wdata = '0;
        test_reset();
        test_solo();
        test_round_robin();
        test_same_cycle();
        test_reset_mid();
        test_addr_ff();
        test_latency2();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
